alarm_ctrl: RTL and testbench



---
 rtl/alarm_pkg.sv | 21 ++
 rtl/alarm_time_set.sv | 55 +++++
 rtl/alarm_ctrl.sv | 128 ++++++++++++
 tb/tb_alarm_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencer and its time-set register.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  localparam logic [6:0] HOUR_MIN     = 7'd1;
  localparam logic [6:0] HOUR_MAX     = 7'd12;
  localparam logic [6:0] MIN_MAX      = 7'd59;
  localparam logic [6:0] DEFAULT_HOUR = 7'd7;
  localparam logic [6:0] DEFAULT_MIN  = 7'd0;
  localparam logic       DEFAULT_AP   = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_time_set.sv
// Alarm time register (12-hour format) with the hour/minute increment and wrap rules.
module alarm_time_set
  import alarm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic       inc_hour,
  input  logic       inc_min,
  output logic       a_ap,
  output logic [6:0] a_hour,
  output logic [6:0] a_min
);

  logic       ap_reg,   ap_next;
  logic [6:0] hour_reg, hour_next;
  logic [6:0] min_reg,  min_next;

  always_comb begin
    ap_next   = ap_reg;
    hour_next = hour_reg;
    min_next  = min_reg;
    if (set_en && inc_hour) begin
      // Crossing 11 -> 12 is the noon/midnight boundary, so AM/PM flips there.
      if (hour_reg == HOUR_MAX - 7'd1) begin
        hour_next = HOUR_MAX;
        ap_next   = ~ap_reg;
      end else if (hour_reg == HOUR_MAX) begin
        hour_next = HOUR_MIN;
      end else begin
        hour_next = hour_reg + 7'd1;
      end
    end
    if (set_en && inc_min) begin
      min_next = (min_reg == MIN_MAX) ? 7'd0 : min_reg + 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ap_reg   <= DEFAULT_AP;
      hour_reg <= DEFAULT_HOUR;
      min_reg  <= DEFAULT_MIN;
    end else begin
      ap_reg   <= ap_next;
      hour_reg <= hour_next;
      min_reg  <= min_next;
    end
  end

  assign a_ap   = ap_reg;
  assign a_hour = hour_reg;
  assign a_min  = min_reg;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm sequencer: holds the alarm time, gates the comparator and runs the
// ring / snooze / stop cycle off the comparator's match edge.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       arm,
  input  logic       set_en,
  input  logic       inc_hour,
  input  logic       inc_min,
  input  logic       btn_stop,
  input  logic       btn_snooze,
  input  logic       match,
  output logic       a_ap,
  output logic [6:0] a_hour,
  output logic [6:0] a_min,
  output logic       cmp_enable,
  output logic       ring,
  output logic       snoozing,
  output logic [1:0] snooze_cnt
);

  localparam int TW = $clog2(max_int(RING_SECONDS, SNOOZE_SECONDS));
  localparam logic [TW-1:0] RING_LAST   = TW'(RING_SECONDS - 1);
  localparam logic [TW-1:0] SNOOZE_LAST = TW'(SNOOZE_SECONDS - 1);
  localparam logic [1:0]    SNOOZE_LIM  = 2'(MAX_SNOOZE);

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [1:0]    cnt_reg,   cnt_next;
  logic          match_d_reg;
  logic          ring_reg, snoozing_reg;
  logic          match_rise;

  alarm_time_set u_time_set (
    .clk      (clk),
    .rst      (rst),
    .set_en   (set_en),
    .inc_hour (inc_hour),
    .inc_min  (inc_min),
    .a_ap     (a_ap),
    .a_hour   (a_hour),
    .a_min    (a_min)
  );

  assign cmp_enable = arm & ~set_en;
  assign match_rise = match & ~match_d_reg;

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    cnt_next   = cnt_reg;
    if (sec_tick && state_reg != IDLE) begin
      timer_next = timer_reg + 1'b1;
    end
    if (set_en || !arm) begin
      state_next = IDLE;
      timer_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (match_rise) begin
            state_next = RINGING;
            timer_next = '0;
            cnt_next   = 2'd0;
          end
        end
        RINGING: begin
          // A snooze beyond the limit falls through to the timeout check.
          if (btn_stop) begin
            state_next = IDLE;
            timer_next = '0;
          end else if (btn_snooze && cnt_reg < SNOOZE_LIM) begin
            state_next = SNOOZE;
            timer_next = '0;
            cnt_next   = cnt_reg + 2'd1;
          end else if (sec_tick && timer_reg == RING_LAST) begin
            state_next = IDLE;
            timer_next = '0;
          end
        end
        SNOOZE: begin
          if (btn_stop) begin
            state_next = IDLE;
            timer_next = '0;
          end else if (sec_tick && timer_reg == SNOOZE_LAST) begin
            state_next = RINGING;
            timer_next = '0;
          end
        end
        default: begin
          state_next = IDLE;
          timer_next = '0;
        end
      endcase
    end
  end

  // match_d resets high so a match already present at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      cnt_reg      <= 2'd0;
      match_d_reg  <= 1'b1;
      ring_reg     <= 1'b0;
      snoozing_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      cnt_reg      <= cnt_next;
      match_d_reg  <= match;
      ring_reg     <= (state_next == RINGING);
      snoozing_reg <= (state_next == SNOOZE);
    end
  end

  assign ring       = ring_reg;
  assign snoozing   = snoozing_reg;
  assign snooze_cnt = cnt_reg;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: directed steps plus a random phase, checked against a
// minutes-of-day / seconds-elapsed reference model.
module tb_alarm_ctrl;

  localparam int RING_S   = 4;
  localparam int SNOOZE_S = 3;
  localparam int MAX_SN   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sec_tick = 1'b0;
  logic       arm = 1'b0;
  logic       set_en = 1'b0;
  logic       inc_hour = 1'b0;
  logic       inc_min = 1'b0;
  logic       btn_stop = 1'b0;
  logic       btn_snooze = 1'b0;
  logic       match = 1'b0;
  logic       a_ap;
  logic [6:0] a_hour;
  logic [6:0] a_min;
  logic       cmp_enable;
  logic       ring;
  logic       snoozing;
  logic [1:0] snooze_cnt;

  int compared = 0;
  int mismatched = 0;
  int div = 0;

  alarm_ctrl #(
    .RING_SECONDS   (RING_S),
    .SNOOZE_SECONDS (SNOOZE_S),
    .MAX_SNOOZE     (MAX_SN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sec_tick   (sec_tick),
    .arm        (arm),
    .set_en     (set_en),
    .inc_hour   (inc_hour),
    .inc_min    (inc_min),
    .btn_stop   (btn_stop),
    .btn_snooze (btn_snooze),
    .match      (match),
    .a_ap       (a_ap),
    .a_hour     (a_hour),
    .a_min      (a_min),
    .cmp_enable (cmp_enable),
    .ring       (ring),
    .snoozing   (snoozing),
    .snooze_cnt (snooze_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: alarm time as minutes since midnight; alarm phase as a
  // mode (0 quiet, 1 ringing, 2 snoozing) plus whole seconds spent in it.
  int m_t = 420;
  int m_mode = 0;
  int m_secs = 0;
  int m_used = 0;
  bit m_prev_match = 1'b1;

  always @(posedge clk) begin
    bit rise;
    if (rst) begin
      m_t = 420; m_mode = 0; m_secs = 0; m_used = 0; m_prev_match = 1'b1;
    end else begin
      rise = match && !m_prev_match;
      m_prev_match = match;
      if (set_en && inc_hour) m_t = (m_t + 60) % 1440;
      if (set_en && inc_min)  m_t = (m_t / 60) * 60 + ((m_t % 60) + 1) % 60;
      if (set_en || !arm) begin
        m_mode = 0;
      end else if (m_mode == 0) begin
        if (rise) begin m_mode = 1; m_secs = 0; m_used = 0; end
      end else if (m_mode == 1) begin
        if (btn_stop) m_mode = 0;
        else if (btn_snooze && m_used < MAX_SN) begin m_mode = 2; m_secs = 0; m_used++; end
        else if (sec_tick) begin
          m_secs++;
          if (m_secs == RING_S) m_mode = 0;
        end
      end else begin
        if (btn_stop) m_mode = 0;
        else if (sec_tick) begin
          m_secs++;
          if (m_secs == SNOOZE_S) begin m_mode = 1; m_secs = 0; end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    int h24;
    h24 = m_t / 60;
    chk("model_hour", 32'(a_hour), (h24 % 12 == 0) ? 32'd12 : 32'(h24 % 12));
    chk("model_min", 32'(a_min), 32'(m_t % 60));
    chk("model_ap", 32'(a_ap), (h24 >= 12) ? 32'd1 : 32'd0);
    chk("model_ring", 32'(ring), (m_mode == 1) ? 32'd1 : 32'd0);
    chk("model_snoozing", 32'(snoozing), (m_mode == 2) ? 32'd1 : 32'd0);
    chk("model_snooze_cnt", 32'(snooze_cnt), 32'(m_used));
    chk("model_cmp_enable", 32'(cmp_enable), 32'(arm && !set_en));
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_model();
      btn_stop = 0; btn_snooze = 0; inc_hour = 0; inc_min = 0;
      div = (div == 9) ? 0 : div + 1;
      sec_tick = (div == 9);
    end
  endtask

  // Returns the number of sec_ticks consumed before ring changes to 'target'.
  task automatic wait_ring(input logic target, output int ticks);
    ticks = 0;
    for (int i = 0; i < 200; i++) begin
      if (ring === target) break;
      if (sec_tick) ticks++;
      step(1);
    end
    chk("wait_ring_bound", 32'(ring), 32'(target));
  endtask

  task automatic retrigger();
    match = 0; step(2);
    match = 1; step(1);
  endtask

  initial begin
    int ticks;
    rst = 1;
    repeat (2) @(negedge clk);
    step(2);
    rst = 0;
    step(1);
    chk("reset_hour", 32'(a_hour), 32'd7);
    chk("reset_min", 32'(a_min), 32'd0);
    chk("reset_ap", 32'(a_ap), 32'd0);
    chk("reset_ring", 32'(ring), 32'd0);
    chk("reset_cnt", 32'(snooze_cnt), 32'd0);

    // Time set
    set_en = 1;
    repeat (5) begin inc_hour = 1; step(1); end
    chk("set_hour12", 32'(a_hour), 32'd12);
    chk("set_ap_pm", 32'(a_ap), 32'd1);
    inc_hour = 1; step(1);
    chk("set_hour1", 32'(a_hour), 32'd1);
    repeat (60) begin inc_min = 1; step(1); end
    chk("set_min_wrap", 32'(a_min), 32'd0);
    chk("set_min_nocarry", 32'(a_hour), 32'd1);
    set_en = 0;
    inc_hour = 1; step(1);
    chk("set_ignored", 32'(a_hour), 32'd1);

    // Trigger and stop
    arm = 1; #1;
    chk("cmp_enable_on", 32'(cmp_enable), 32'd1);
    step(1);
    match = 1; step(1);
    chk("trigger_ring", 32'(ring), 32'd1);
    btn_stop = 1; step(1);
    chk("stop_ring", 32'(ring), 32'd0);
    step(100);
    chk("no_retrigger", 32'(ring), 32'd0);

    // Timeout
    retrigger();
    chk("timeout_start", 32'(ring), 32'd1);
    wait_ring(1'b0, ticks);
    chk("timeout_ticks", 32'(ticks), 32'(RING_S));

    // Snooze limit
    retrigger();
    btn_snooze = 1; step(1);
    chk("snooze1_on", 32'(snoozing), 32'd1);
    chk("snooze1_cnt", 32'(snooze_cnt), 32'd1);
    wait_ring(1'b1, ticks);
    chk("snooze1_ticks", 32'(ticks), 32'(SNOOZE_S));
    btn_snooze = 1; step(1);
    chk("snooze2_cnt", 32'(snooze_cnt), 32'd2);
    wait_ring(1'b1, ticks);
    btn_snooze = 1; step(1);
    chk("snooze3_ignored", 32'(ring), 32'd1);
    chk("snooze3_cnt", 32'(snooze_cnt), 32'd2);

    // Stop beats snooze
    btn_stop = 1; btn_snooze = 1; step(1);
    chk("prio_ring", 32'(ring), 32'd0);
    chk("prio_snoozing", 32'(snoozing), 32'd0);
    chk("prio_cnt", 32'(snooze_cnt), 32'd2);

    // Overrides mid-snooze
    retrigger();
    chk("retrig_cnt_clear", 32'(snooze_cnt), 32'd0);
    btn_snooze = 1; step(1);
    arm = 0; #1;
    chk("disarm_cmp", 32'(cmp_enable), 32'd0);
    step(1);
    chk("disarm_snoozing", 32'(snoozing), 32'd0);
    arm = 1;
    retrigger();
    btn_snooze = 1; step(1);
    set_en = 1; #1;
    chk("set_cmp", 32'(cmp_enable), 32'd0);
    step(1);
    chk("set_snoozing", 32'(snoozing), 32'd0);
    set_en = 0;

    // Reset mid-ring, match high at release
    retrigger();
    chk("pre_rst_ring", 32'(ring), 32'd1);
    rst = 1; step(1);
    chk("rst_ring", 32'(ring), 32'd0);
    chk("rst_hour", 32'(a_hour), 32'd7);
    chk("rst_min", 32'(a_min), 32'd0);
    chk("rst_ap", 32'(a_ap), 32'd0);
    chk("rst_cnt", 32'(snooze_cnt), 32'd0);
    rst = 0; step(5);
    chk("match_at_release", 32'(ring), 32'd0);

    // Random phase
    for (int i = 0; i < 800; i++) begin
      arm        = ($urandom_range(0, 49) != 0);
      set_en     = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 24) == 0) match = ~match;
      btn_stop   = ($urandom_range(0, 39) == 0);
      btn_snooze = ($urandom_range(0, 9) == 0);
      inc_hour   = ($urandom_range(0, 7) == 0);
      inc_min    = ($urandom_range(0, 7) == 0);
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
